// File: rtl/cdb_arbiter_if.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle between the result producers / CDB consumers and cdb_arbiter.
//
// Signals
//   req_valid    [NUM_REQ]            requester i has a result
//   req_payload  [NUM_REQ*PAYLOAD_W]  requester i payload at [i*PAYLOAD_W +: PAYLOAD_W]
//   req_ready    [NUM_REQ]            grant, combinational, same cycle
//   bus_valid    [NUM_BUS]            lane b carries a result
//   bus_payload  [NUM_BUS*PAYLOAD_W]  lane b payload at [b*PAYLOAD_W +: PAYLOAD_W]
//   bus_src      [NUM_BUS*ID_W]       lane b source ID (winner index + 1), 0 when idle
//
// Modports
//   master : producer/consumer side (drives requests, observes grants and lanes)
//   slave  : arbiter side
// ----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int NUM_REQ   = 5,
    parameter int NUM_BUS   = 2,
    parameter int PAYLOAD_W = 70,
    parameter int ID_W      = 8
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_BUS-1:0]           bus_valid;
    logic [NUM_BUS*PAYLOAD_W-1:0] bus_payload;
    logic [NUM_BUS*ID_W-1:0]      bus_src;

    modport master (
        output req_valid,
        output req_payload,
        input  req_ready,
        input  bus_valid,
        input  bus_payload,
        input  bus_src
    );

    modport slave (
        input  req_valid,
        input  req_payload,
        output req_ready,
        output bus_valid,
        output bus_payload,
        output bus_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
// Arbitrates NUM_REQ result producers onto NUM_BUS common data bus lanes.
// Up to NUM_BUS distinct winners per cycle; the k-th winner in scan order is
// registered onto lane k (latency 1). Scan starts at a rotating round-robin
// pointer that moves just past the last winner.
//
// Ports
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-low
//   flush  in  suppresses all grants this cycle (pointer held)
//   cdb    cdb_arbiter_if.slave : request/grant and CDB lane signals
//
// Build option
//   CDB_ARB_FIXED_PRIO_EN : when defined the pointer is removed and scanning
//   always starts at index 0 (fixed priority, lowest index wins).
// ----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int NUM_BUS   = 2,
    parameter int PAYLOAD_W = 70,
    parameter int ID_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  cdb
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_BUS + 1);

    logic [PTR_W-1:0]     scan_base;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_BUS-1:0]   lane_hit;
    logic [PTR_W-1:0]     lane_idx     [NUM_BUS];
    logic [PAYLOAD_W-1:0] lane_payload [NUM_BUS];
    logic [PTR_W-1:0]     last_idx;

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    assign scan_base = ptr_reg;

    // Explicit wrap so NUM_REQ need not be a power of two.
    always_comb begin
        ptr_next = ptr_reg;
        if (|lane_hit) begin
            if (last_idx == PTR_W'(NUM_REQ - 1))
                ptr_next = '0;
            else
                ptr_next = last_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            ptr_reg <= '0;
        else
            ptr_reg <= ptr_next;
    end
`endif

    // Scan from scan_base upward (modulo NUM_REQ); the first NUM_BUS valid
    // requesters win, in order, onto lanes 0..NUM_BUS-1.
    always_comb begin
        logic [PTR_W:0]   idx_wide;
        logic [PTR_W-1:0] idx;
        logic [CNT_W-1:0] cnt;

        grant    = '0;
        lane_hit = '0;
        last_idx = scan_base;
        cnt      = '0;
        idx_wide = '0;
        idx      = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            lane_idx[b]     = '0;
            lane_payload[b] = '0;
        end

        for (int j = 0; j < NUM_REQ; j++) begin
            idx_wide = {1'b0, scan_base} + (PTR_W+1)'(j);
            if (idx_wide >= (PTR_W+1)'(NUM_REQ))
                idx_wide = idx_wide - (PTR_W+1)'(NUM_REQ);
            idx = idx_wide[PTR_W-1:0];
            if (cdb.req_valid[idx] && (cnt < CNT_W'(NUM_BUS))) begin
                grant[idx] = 1'b1;
                for (int b = 0; b < NUM_BUS; b++) begin
                    if (cnt == CNT_W'(b)) begin
                        lane_hit[b]     = 1'b1;
                        lane_idx[b]     = idx;
                        lane_payload[b] = cdb.req_payload[int'(idx)*PAYLOAD_W +: PAYLOAD_W];
                    end
                end
                last_idx = idx;
                cnt      = cnt + CNT_W'(1);
            end
        end

        // Flush and reset both cancel every grant; in-flight results drop.
        if (flush || !reset) begin
            grant    = '0;
            lane_hit = '0;
        end
    end

    assign cdb.req_ready = grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUS; gi++) begin : g_lane
            logic                 valid_reg;
            logic [ID_W-1:0]      src_reg;
            logic [PAYLOAD_W-1:0] payload_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    valid_reg   <= 1'b0;
                    src_reg     <= '0;
                    payload_reg <= '0;
                end else begin
                    valid_reg <= lane_hit[gi];
                    src_reg   <= lane_hit[gi] ? (ID_W'(lane_idx[gi]) + ID_W'(1)) : '0;
                    // Idle-lane payload is don't-care; only load on a win.
                    if (lane_hit[gi])
                        payload_reg <= lane_payload[gi];
                end
            end

            assign cdb.bus_valid[gi]                          = valid_reg;
            assign cdb.bus_src[gi*ID_W +: ID_W]               = src_reg;
            assign cdb.bus_payload[gi*PAYLOAD_W +: PAYLOAD_W] = payload_reg;
        end
    endgenerate

endmodule

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter (NUM_REQ=5, NUM_BUS=2, PAYLOAD_W=70, ID_W=8).
// Inputs change on the falling edge; req_ready is sampled 1ns later, lane
// outputs 1ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_cdb_arbiter;
    localparam int NUM_REQ   = 5;
    localparam int NUM_BUS   = 2;
    localparam int PAYLOAD_W = 70;
    localparam int ID_W      = 8;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   failures;

    cdb_arbiter_if #(
        .NUM_REQ(NUM_REQ), .NUM_BUS(NUM_BUS), .PAYLOAD_W(PAYLOAD_W), .ID_W(ID_W)
    ) cdb ();

    cdb_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_BUS(NUM_BUS), .PAYLOAD_W(PAYLOAD_W), .ID_W(ID_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .cdb   (cdb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PAYLOAD_W-1:0] pl(input int i);
        return {6'h2A, 32'hC0DE_0000 | 32'(i), 32'h1111_0000 | 32'(i)};
    endfunction

    task automatic set_reqs(input logic [NUM_REQ-1:0] v);
        cdb.req_valid = v;
        for (int i = 0; i < NUM_REQ; i++)
            cdb.req_payload[i*PAYLOAD_W +: PAYLOAD_W] = pl(i);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        set_reqs(5'b11111);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (cdb.req_ready !== 5'b00000) begin
                failures++;
                $display("FAIL reset_ready cyc=%0d got=%b want=00000", c, cdb.req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (cdb.bus_valid !== 2'b00 || cdb.bus_src !== 16'h0000 || cdb.bus_payload !== '0) begin
                failures++;
                $display("FAIL reset_bus cyc=%0d got valid=%b src=%h want valid=00 src=0000 payload=0",
                         c, cdb.bus_valid, cdb.bus_src);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cdb.req_ready !== 5'b00011) begin
            failures++;
            $display("FAIL reset_first_grant got=%b want=00011", cdb.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb.bus_valid !== 2'b11 || cdb.bus_src !== {8'h02, 8'h01}) begin
            failures++;
            $display("FAIL reset_first_lanes got valid=%b src=%h want valid=11 src=0201",
                     cdb.bus_valid, cdb.bus_src);
        end
        checks++;
        if (cdb.bus_payload !== {pl(1), pl(0)}) begin
            failures++;
            $display("FAIL reset_first_payload got=%h want=%h", cdb.bus_payload, {pl(1), pl(0)});
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

`ifndef CDB_ARB_FIXED_PRIO_EN
    task automatic test_saturation();
        logic [NUM_REQ-1:0] exp_grant [4];
        logic [15:0]        exp_src   [4];
        int                 exp_lane0 [4];
        exp_grant = '{5'b00011, 5'b01100, 5'b10001, 5'b00110};
        exp_src   = '{16'h0201, 16'h0403, 16'h0105, 16'h0302};
        exp_lane0 = '{0, 2, 4, 1};

        // Reset mid-operation: lanes were busy, must clear.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cdb.bus_valid !== 2'b00 || cdb.bus_src !== 16'h0000) begin
            failures++;
            $display("FAIL midreset_bus got valid=%b src=%h want 00/0000", cdb.bus_valid, cdb.bus_src);
        end
        @(negedge clk);
        reset = 1'b1;
        set_reqs(5'b11111);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (cdb.req_ready !== exp_grant[k]) begin
                failures++;
                $display("FAIL sat_ready step=%0d got=%b want=%b", k, cdb.req_ready, exp_grant[k]);
            end
            @(posedge clk); #1;
            checks++;
            if (cdb.bus_valid !== 2'b11 || cdb.bus_src !== exp_src[k]) begin
                failures++;
                $display("FAIL sat_lanes step=%0d got valid=%b src=%h want valid=11 src=%h",
                         k, cdb.bus_valid, cdb.bus_src, exp_src[k]);
            end
            checks++;
            if (cdb.bus_payload[PAYLOAD_W-1:0] !== pl(exp_lane0[k])) begin
                failures++;
                $display("FAIL sat_payload0 step=%0d got=%h want=%h",
                         k, cdb.bus_payload[PAYLOAD_W-1:0], pl(exp_lane0[k]));
            end
            $display("saturation step=%0d ready=%b src=%h", k, exp_grant[k], cdb.bus_src);
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        // Pointer is 3 after saturation.
        set_reqs(5'b01000);
        cdb.req_payload[3*PAYLOAD_W +: PAYLOAD_W] = 70'hDEADBEEF;
        #1;
        checks++;
        if (cdb.req_ready !== 5'b01000) begin
            failures++;
            $display("FAIL single_ready got=%b want=01000", cdb.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb.bus_valid !== 2'b01 || cdb.bus_src !== 16'h0004) begin
            failures++;
            $display("FAIL single_lanes got valid=%b src=%h want valid=01 src=0004",
                     cdb.bus_valid, cdb.bus_src);
        end
        checks++;
        if (cdb.bus_payload[PAYLOAD_W-1:0] !== 70'hDEADBEEF) begin
            failures++;
            $display("FAIL single_payload got=%h want=DEADBEEF", cdb.bus_payload[PAYLOAD_W-1:0]);
        end
        $display("single ready=01000 src=%h", cdb.bus_src);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        // Pointer is 4: scan 4 then wraps to 0,1.
        set_reqs(5'b10010);
        #1;
        checks++;
        if (cdb.req_ready !== 5'b10010) begin
            failures++;
            $display("FAIL wrap_ready got=%b want=10010", cdb.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb.bus_valid !== 2'b11 || cdb.bus_src !== {8'h02, 8'h05}) begin
            failures++;
            $display("FAIL wrap_lanes got valid=%b src=%h want valid=11 src=0205",
                     cdb.bus_valid, cdb.bus_src);
        end
        checks++;
        if (cdb.bus_payload !== {pl(1), pl(4)}) begin
            failures++;
            $display("FAIL wrap_payload got=%h want=%h", cdb.bus_payload, {pl(1), pl(4)});
        end
        $display("wrap ready=10010 src=%h", cdb.bus_src);
        // Pointer should now be 2: with 0,1,2 valid the scan picks 2 then 0.
        @(negedge clk);
        set_reqs(5'b00111);
        #1;
        checks++;
        if (cdb.req_ready !== 5'b00101) begin
            failures++;
            $display("FAIL wrap_ptr_ready got=%b want=00101", cdb.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb.bus_valid !== 2'b11 || cdb.bus_src !== {8'h01, 8'h03}) begin
            failures++;
            $display("FAIL wrap_ptr_lanes got valid=%b src=%h want valid=11 src=0103",
                     cdb.bus_valid, cdb.bus_src);
        end
        $display("wrap_ptr ready=00101 src=%h", cdb.bus_src);
        @(negedge clk);
    endtask

    task automatic test_flush();
        // Return pointer to 0 so the post-flush grant order is known.
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b1;
        set_reqs(5'b00011);
        #1;
        checks++;
        if (cdb.req_ready !== 5'b00000) begin
            failures++;
            $display("FAIL flush_ready got=%b want=00000", cdb.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb.bus_valid !== 2'b00 || cdb.bus_src !== 16'h0000) begin
            failures++;
            $display("FAIL flush_lanes got valid=%b src=%h want valid=00 src=0000",
                     cdb.bus_valid, cdb.bus_src);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (cdb.req_ready !== 5'b00011) begin
            failures++;
            $display("FAIL postflush_ready got=%b want=00011", cdb.req_ready);
        end
        @(posedge clk); #1;
        // Pointer held at 0 across the flush, so lane0 gets index 0.
        checks++;
        if (cdb.bus_valid !== 2'b11 || cdb.bus_src !== {8'h02, 8'h01}) begin
            failures++;
            $display("FAIL postflush_lanes got valid=%b src=%h want valid=11 src=0201",
                     cdb.bus_valid, cdb.bus_src);
        end
        $display("flush then release src=%h", cdb.bus_src);
        @(negedge clk);
    endtask

    task automatic test_idle();
        set_reqs(5'b00000);
        #1;
        checks++;
        if (cdb.req_ready !== 5'b00000) begin
            failures++;
            $display("FAIL idle_ready got=%b want=00000", cdb.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb.bus_valid !== 2'b00 || cdb.bus_src !== 16'h0000) begin
            failures++;
            $display("FAIL idle_lanes got valid=%b src=%h want valid=00 src=0000",
                     cdb.bus_valid, cdb.bus_src);
        end
        $display("idle src=%h", cdb.bus_src);
        @(negedge clk);
    endtask
`else
    task automatic test_fixed_prio();
        @(negedge clk);
        set_reqs(5'b11111);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (cdb.req_ready !== 5'b00011) begin
                failures++;
                $display("FAIL fixed_ready step=%0d got=%b want=00011", k, cdb.req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (cdb.bus_valid !== 2'b11 || cdb.bus_src !== {8'h02, 8'h01}) begin
                failures++;
                $display("FAIL fixed_lanes step=%0d got valid=%b src=%h want valid=11 src=0201",
                         k, cdb.bus_valid, cdb.bus_src);
            end
            $display("fixed step=%0d src=%h", k, cdb.bus_src);
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        flush           = 1'b0;
        cdb.req_valid   = '0;
        cdb.req_payload = '0;
        test_reset();
`ifndef CDB_ARB_FIXED_PRIO_EN
        test_saturation();
        test_single();
        test_wrap();
        test_flush();
        test_idle();
`else
        test_fixed_prio();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
